// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin front end for the single-port sram_model.
// After reset the SRAM is zero-filled (CLEAR_ON_RESET = 1) and then valid/ready
// requests from p0 and p1 are served with a fixed 2-cycle latency.
// Optional build macro SRAM_ARB_PERF_EN adds saturating grant/conflict counters.

module sram_arbiter #(
  parameter int AW             = 8,
  parameter int DW             = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            io_p0_valid,
  output logic            io_p0_ready,
  input  logic [AW-1:0]   io_p0_adr,
  input  logic            io_p0_wen,
  input  logic [DW/8-1:0] io_p0_wstrb,
  input  logic [DW-1:0]   io_p0_d,
  output logic            io_p0_rsp_valid,

  input  logic            io_p1_valid,
  output logic            io_p1_ready,
  input  logic [AW-1:0]   io_p1_adr,
  input  logic            io_p1_wen,
  input  logic [DW/8-1:0] io_p1_wstrb,
  input  logic [DW-1:0]   io_p1_d,
  output logic            io_p1_rsp_valid,

  output logic [DW-1:0]   io_rsp_rdata,
  output logic            io_init_done,

  output logic [AW-1:0]   io_sram_adr,
  output logic            io_sram_cen,
  output logic            io_sram_wen,
  output logic [DW/8-1:0] io_sram_wstrb,
  output logic [DW-1:0]   io_sram_d,
  input  logic [DW-1:0]   io_sram_q
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]     io_perf_p0_grants,
  output logic [31:0]     io_perf_p1_grants,
  output logic [31:0]     io_perf_conflicts
`endif
);

  localparam int SW = DW / 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   init_cnt;
  logic            rr_ptr;

  logic            in_run;
  logic            grant0;
  logic            grant1;
  logic            grant_any;

  logic [AW-1:0]   sel_adr;
  logic            sel_wen;
  logic [SW-1:0]   sel_wstrb;
  logic [DW-1:0]   sel_d;

  // Stage 1 tracks the access currently on io_sram_*, stage 2 the one whose
  // response is being returned this cycle.
  logic            s1_valid;
  logic            s1_port;
  logic            s1_rd;
  logic            s2_valid;
  logic            s2_port;
  logic            s2_rd;

  logic            clear_en;
  logic            init_last;

  assign clear_en  = (CLEAR_ON_RESET != 0);
  assign init_last = (init_cnt == {AW{1'b1}});

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave INIT after the last clear write (or at once when
  // clearing is disabled)
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (!clear_en || init_last) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: same-cycle round-robin grant, only while in RUN
  always_comb begin
    in_run      = (state == ST_RUN);
    grant0      = in_run && io_p0_valid && (!io_p1_valid || (rr_ptr == 1'b0));
    grant1      = in_run && io_p1_valid && (!io_p0_valid || (rr_ptr == 1'b1));
    grant_any   = grant0 || grant1;
    io_p0_ready = grant0;
    io_p1_ready = grant1;
    io_init_done = in_run;
  end

  // Request field mux for the granted port; strobes are dropped on reads
  always_comb begin
    if (grant1) begin
      sel_adr   = io_p1_adr;
      sel_wen   = io_p1_wen;
      sel_wstrb = io_p1_wen ? io_p1_wstrb : '0;
      sel_d     = io_p1_d;
    end else begin
      sel_adr   = io_p0_adr;
      sel_wen   = io_p0_wen;
      sel_wstrb = io_p0_wen ? io_p0_wstrb : '0;
      sel_d     = io_p0_d;
    end
  end

  // Clear-address counter, advances once per INIT write
  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state == ST_INIT && clear_en) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Round-robin pointer: after a grant the other port gets priority
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant_any) begin
      rr_ptr <= ~grant1;
    end
  end

  // Registered SRAM interface; non-enable fields hold when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      io_sram_cen   <= 1'b0;
      io_sram_wen   <= 1'b0;
      io_sram_adr   <= '0;
      io_sram_wstrb <= '0;
      io_sram_d     <= '0;
    end else if (state == ST_INIT && clear_en) begin
      io_sram_cen   <= 1'b1;
      io_sram_wen   <= 1'b1;
      io_sram_adr   <= init_cnt;
      io_sram_wstrb <= '1;
      io_sram_d     <= '0;
    end else if (grant_any) begin
      io_sram_cen   <= 1'b1;
      io_sram_wen   <= sel_wen;
      io_sram_adr   <= sel_adr;
      io_sram_wstrb <= sel_wstrb;
      io_sram_d     <= sel_d;
    end else begin
      io_sram_cen   <= 1'b0;
    end
  end

  // Response pipeline; reset drops anything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
      s1_rd    <= 1'b0;
      s2_valid <= 1'b0;
      s2_port  <= 1'b0;
      s2_rd    <= 1'b0;
    end else begin
      s1_valid <= grant_any;
      s1_port  <= grant1;
      s1_rd    <= grant_any && !sel_wen;
      s2_valid <= s1_valid;
      s2_port  <= s1_port;
      s2_rd    <= s1_valid && s1_rd;
    end
  end

  // Response outputs: read data comes straight from the SRAM output latch
  always_comb begin
    io_p0_rsp_valid = s2_valid && (s2_port == 1'b0);
    io_p1_rsp_valid = s2_valid && (s2_port == 1'b1);
    io_rsp_rdata    = (s2_valid && s2_rd) ? io_sram_q : '0;
  end

`ifdef SRAM_ARB_PERF_EN
  logic both_valid_run;

  assign both_valid_run = in_run && io_p0_valid && io_p1_valid;

  // Saturating performance counters, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_p0_grants <= '0;
      io_perf_p1_grants <= '0;
      io_perf_conflicts <= '0;
    end else begin
      if (grant0 && io_perf_p0_grants != 32'hFFFF_FFFF) begin
        io_perf_p0_grants <= io_perf_p0_grants + 32'd1;
      end
      if (grant1 && io_perf_p1_grants != 32'hFFFF_FFFF) begin
        io_perf_p1_grants <= io_perf_p1_grants + 32'd1;
      end
      if (both_valid_run && io_perf_conflicts != 32'hFFFF_FFFF) begin
        io_perf_conflicts <= io_perf_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural single-port SRAM.
// Build with SRAM_ARB_PERF_EN defined to also exercise the perf counters.

module tb_sram_arbiter;

  logic        clock;
  logic        reset;

  logic        p0_valid, p0_ready, p0_wen, p0_rsp_valid;
  logic [7:0]  p0_adr;
  logic [3:0]  p0_wstrb;
  logic [31:0] p0_d;
  logic        p1_valid, p1_ready, p1_wen, p1_rsp_valid;
  logic [7:0]  p1_adr;
  logic [3:0]  p1_wstrb;
  logic [31:0] p1_d;

  logic [31:0] rsp_rdata;
  logic        init_done;
  logic [7:0]  sram_adr;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_d;
  logic [31:0] sram_q;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_p0, perf_p1, perf_conf;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  sram_arbiter #(.AW(8), .DW(32), .CLEAR_ON_RESET(1)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_p0_valid     (p0_valid),
    .io_p0_ready     (p0_ready),
    .io_p0_adr       (p0_adr),
    .io_p0_wen       (p0_wen),
    .io_p0_wstrb     (p0_wstrb),
    .io_p0_d         (p0_d),
    .io_p0_rsp_valid (p0_rsp_valid),
    .io_p1_valid     (p1_valid),
    .io_p1_ready     (p1_ready),
    .io_p1_adr       (p1_adr),
    .io_p1_wen       (p1_wen),
    .io_p1_wstrb     (p1_wstrb),
    .io_p1_d         (p1_d),
    .io_p1_rsp_valid (p1_rsp_valid),
    .io_rsp_rdata    (rsp_rdata),
    .io_init_done    (init_done),
    .io_sram_adr     (sram_adr),
    .io_sram_cen     (sram_cen),
    .io_sram_wen     (sram_wen),
    .io_sram_wstrb   (sram_wstrb),
    .io_sram_d       (sram_d),
    .io_sram_q       (sram_q)
`ifdef SRAM_ARB_PERF_EN
    ,
    .io_perf_p0_grants (perf_p0),
    .io_perf_p1_grants (perf_p1),
    .io_perf_conflicts (perf_conf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural single-port SRAM: q valid the cycle after a read access
  always @(posedge clock) begin
    if (sram_cen) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wstrb[b]) mem[sram_adr][b*8 +: 8] <= sram_d[b*8 +: 8];
        end
      end else begin
        sram_q <= mem[sram_adr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Single isolated access on one port; returns handshake and response observations
  task automatic access(input int port, input logic [7:0] adr, input logic wen,
                        input logic [3:0] strb, input logic [31:0] d,
                        output bit granted, output bit early_rsp,
                        output bit rsp_own, output bit rsp_other,
                        output logic [31:0] rdata);
    @(negedge clock);
    if (port == 0) begin
      p0_adr = adr; p0_wen = wen; p0_wstrb = strb; p0_d = d; p0_valid = 1'b1;
    end else begin
      p1_adr = adr; p1_wen = wen; p1_wstrb = strb; p1_d = d; p1_valid = 1'b1;
    end
    granted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port == 0) ? p0_ready : p1_ready) begin
        granted = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    early_rsp = p0_rsp_valid | p1_rsp_valid;
    @(negedge clock);
    rsp_own   = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    rsp_other = (port == 0) ? p1_rsp_valid : p0_rsp_valid;
    rdata     = rsp_rdata;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 400) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cycles;
    bit g, e, o, x;
    logic [31:0] rd;
    reset = 1'b1;
    p0_valid = 1'b1; p0_adr = 8'h00; p0_wen = 1'b0; p0_wstrb = 4'h0; p0_d = '0;
    p1_valid = 1'b0; p1_adr = 8'h00; p1_wen = 1'b0; p1_wstrb = 4'h0; p1_d = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({init_done, p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, sram_cen} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {init_done, p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, sram_cen});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 00000000", rsp_rdata);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({sram_cen, sram_wen, sram_wstrb, sram_adr, sram_d} !== {1'b1, 1'b1, 4'hF, 8'h00, 32'h0}) begin
      errors++;
      $display("FAIL init_first_write got cen=%b wen=%b strb=%h adr=%h d=%h exp 1 1 f 00 00000000",
               sram_cen, sram_wen, sram_wstrb, sram_adr, sram_d);
    end
    checks++;
    if (p0_ready !== 1'b0) begin
      errors++; $display("FAIL init_ready got %b exp 0", p0_ready);
    end
    p0_valid = 1'b0;
    wait_init(cycles);
    cycles = cycles + 1;
    checks++;
    if (cycles != 256) begin
      errors++; $display("FAIL init_duration got %0d exp 256", cycles);
    end
    checks++;
    if ({sram_cen, sram_adr} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL init_last_write got cen=%b adr=%h exp 1 ff", sram_cen, sram_adr);
    end
    access(0, 8'hA7, 1'b0, 4'hF, 32'h0, g, e, o, x, rd);
    checks++;
    if ({g, e, o, x} !== 4'b1010 || rd !== 32'h0) begin
      errors++; $display("FAIL cleared_read got g/e/o/x=%b rdata=%h exp 1010 00000000", {g, e, o, x}, rd);
    end
  endtask

  task automatic test_write_read();
    bit g, e, o, x;
    logic [31:0] rd;
    access(0, 8'h10, 1'b1, 4'hF, 32'hDEADBEEF, g, e, o, x, rd);
    checks++;
    if ({g, e, o, x} !== 4'b1010 || rd !== 32'h0) begin
      errors++; $display("FAIL write_rsp got g/e/o/x=%b rdata=%h exp 1010 00000000", {g, e, o, x}, rd);
    end
    access(0, 8'h10, 1'b0, 4'h0, 32'h0, g, e, o, x, rd);
    checks++;
    if ({g, e, o, x} !== 4'b1010 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read got g/e/o/x=%b rdata=%h exp 1010 deadbeef", {g, e, o, x}, rd);
    end
  endtask

  task automatic test_strobe();
    bit g, e, o, x;
    logic [31:0] rd;
    access(0, 8'h20, 1'b1, 4'hF, 32'h11223344, g, e, o, x, rd);
    access(0, 8'h20, 1'b1, 4'h5, 32'hAABBCCDD, g, e, o, x, rd);
    access(0, 8'h20, 1'b0, 4'h0, 32'h0, g, e, o, x, rd);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++; $display("FAIL strobe_merge got %h exp 11bb33dd", rd);
    end
    // p1 path, with a stray strobe that must not matter on a read
    access(1, 8'h20, 1'b0, 4'hA, 32'hFFFFFFFF, g, e, o, x, rd);
    checks++;
    if ({g, e, o, x} !== 4'b1010 || rd !== 32'h11BB33DD) begin
      errors++; $display("FAIL p1_read got g/e/o/x=%b rdata=%h exp 1010 11bb33dd", {g, e, o, x}, rd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    p0_adr = 8'h30; p0_wen = 1'b1; p0_wstrb = 4'hF; p0_d = 32'h55667788; p0_valid = 1'b1;
    #1;
    checks++;
    if (p0_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_write_ready got %b exp 1", p0_ready);
    end
    @(negedge clock);
    p0_wen = 1'b0; p0_d = 32'h0;
    #1;
    checks++;
    if (p0_ready !== 1'b1 || p0_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_read_ready got ready=%b rsp=%b exp 1 0", p0_ready, p0_rsp_valid);
    end
    @(negedge clock);
    p0_valid = 1'b0;
    #1;
    checks++;
    if (p0_rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL b2b_write_rsp got rsp=%b rdata=%h exp 1 00000000", p0_rsp_valid, rsp_rdata);
    end
    @(negedge clock);
    checks++;
    if (p0_rsp_valid !== 1'b1 || rsp_rdata !== 32'h55667788) begin
      errors++; $display("FAIL b2b_raw_read got rsp=%b rdata=%h exp 1 55667788", p0_rsp_valid, rsp_rdata);
    end
    @(negedge clock);
    checks++;
    if (p0_rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL b2b_idle got rsp=%b rdata=%h exp 0 00000000", p0_rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    @(negedge clock);
    p0_adr = 8'h10; p0_wen = 1'b0; p0_wstrb = 4'h0; p0_valid = 1'b1;
    #1;
    checks++;
    if (p0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got %b exp 1", p0_ready);
    end
    @(negedge clock);
    p0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({p0_rsp_valid, p1_rsp_valid, init_done} !== 3'b000) begin
      errors++; $display("FAIL midrst_drop got rsp0/rsp1/done=%b exp 000", {p0_rsp_valid, p1_rsp_valid, init_done});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({p0_rsp_valid, sram_cen, sram_wen, sram_adr} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL midrst_reinit got rsp=%b cen=%b wen=%b adr=%h exp 0 1 1 00",
               p0_rsp_valid, sram_cen, sram_wen, sram_adr);
    end
    wait_init(cycles);
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL midrst_init_done got %b exp 1", init_done);
    end
  endtask

  task automatic test_contention();
    int exp_port;
    // Last pre-reset grant was p0, so p0 winning here shows rr_ptr was reset
    @(negedge clock);
    p0_adr = 8'h40; p0_wen = 1'b1; p0_wstrb = 4'hF; p0_d = 32'hA0A0A0A0; p0_valid = 1'b1;
    p1_adr = 8'h41; p1_wen = 1'b1; p1_wstrb = 4'hF; p1_d = 32'hB1B1B1B1; p1_valid = 1'b1;
    #1;
    checks++;
    if ({p0_ready, p1_ready} !== 2'b10) begin
      errors++; $display("FAIL rr_after_reset got %b exp 10", {p0_ready, p1_ready});
    end
    @(negedge clock);
    p0_valid = 1'b0;
    #1;
    checks++;
    if ({p0_ready, p1_ready} !== 2'b01) begin
      errors++; $display("FAIL preload_p1 got %b exp 01", {p0_ready, p1_ready});
    end
    @(negedge clock);
    p1_valid = 1'b0;
    repeat (2) @(negedge clock);
    p0_adr = 8'h40; p0_wen = 1'b0; p0_wstrb = 4'h0;
    p1_adr = 8'h41; p1_wen = 1'b0; p1_wstrb = 4'h0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      p0_valid = (k < 10);
      p1_valid = (k < 10);
      #1;
      if (k < 10) begin
        checks++;
        if ({p0_ready, p1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant k=%0d got %b exp %b", k, {p0_ready, p1_ready},
                   (k % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (k >= 2 && k < 12) begin
        exp_port = (k - 2) % 2;
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid} !== ((exp_port == 0) ? 2'b10 : 2'b01) ||
            rsp_rdata !== ((exp_port == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin
          errors++;
          $display("FAIL rr_rsp k=%0d got rsp=%b rdata=%h exp port %0d", k,
                   {p0_rsp_valid, p1_rsp_valid}, rsp_rdata, exp_port);
        end
      end
      if (k >= 12) begin
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin
          errors++; $display("FAIL rr_drain k=%0d got %b exp 00", k, {p0_rsp_valid, p1_rsp_valid});
        end
      end
    end
  endtask

`ifdef SRAM_ARB_PERF_EN
  task automatic test_perf();
    // Since the last reset: preload gave 1 grant each and 1 contested cycle,
    // then 10 contested cycles gave 5 grants each.
    checks++;
    if (perf_conf !== 32'd11) begin
      errors++; $display("FAIL perf_conflicts got %0d exp 11", perf_conf);
    end
    checks++;
    if (perf_p0 !== 32'd6 || perf_p1 !== 32'd6) begin
      errors++; $display("FAIL perf_grants got p0=%0d p1=%0d exp 6 6", perf_p0, perf_p1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_back_to_back();
    test_reset_mid();
    test_contention();
`ifdef SRAM_ARB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin controller driving the single-port sram_model (8-bit address, 32-bit data, 4-bit byte strobe).
- After reset it zero-fills the whole SRAM, then serves valid/ready requests from ports p0 and p1.
- Accepts at most one request per cycle and returns one response per accepted request.
- Sits between the core-side memory clients and sram_model.

Parameters:
- AW, 8, SRAM address width; depth = 2^AW.
- DW, 32, data width; strobe width = DW/8.
- CLEAR_ON_RESET, 1, 1 = zero-fill the SRAM after reset; 0 = skip straight to RUN.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- io_pN_valid  input  1  request valid (N = 0, 1).
- io_pN_ready  output  1  request accepted this cycle.
- io_pN_adr  input  AW  request address.
- io_pN_wen  input  1  1 = write, 0 = read.
- io_pN_wstrb  input  DW/8  byte strobes (write only).
- io_pN_d  input  DW  write data.
- io_pN_rsp_valid  output  1  response for port N.
- io_rsp_rdata  output  DW  read data, shared by both ports.
- io_init_done  output  1  high once the block is in RUN.
- io_sram_adr  output  AW  to sram_model io_adr.
- io_sram_cen  output  1  to io_cen; 1 = access.
- io_sram_wen  output  1  to io_wen; 1 = write.
- io_sram_wstrb  output  DW/8  to io_wstrb.
- io_sram_d  output  DW  to io_d.
- io_sram_q  input  DW  from io_q; valid the cycle after a read access.

Behaviour:
- Reset state: state = INIT, init_cnt = 0, rr_ptr = 0, pipeline valid bits = 0.
- Reset output values: all outputs 0, including io_init_done, ready, rsp_valid and sram_cen.
- INIT (CLEAR_ON_RESET = 1):
  - One write per cycle: cen = 1, wen = 1, wstrb = all ones, d = 0, adr = init_cnt; init_cnt increments.
  - After the write to adr 2^AW-1, go to RUN (256 INIT cycles at AW = 8).
  - ready = 0 throughout INIT.
- With CLEAR_ON_RESET = 0, go to RUN on the first cycle after reset deasserts.
- RUN:
  - io_init_done = 1.
  - Grant is combinational in the same cycle. Only one valid: grant it. Both valid: grant port rr_ptr.
  - io_pN_ready = granted N.
  - On any grant, rr_ptr <= the other port.
- Requester rule: hold valid and all request fields stable until ready. The block does not check this.
- Pipeline timing, handshake in cycle T:
  - T+1: io_sram_* carries the request as registered outputs with cen = 1. The SRAM samples at the end of T+1.
  - T+2: io_pN_rsp_valid = 1 for exactly one cycle. Reads: io_rsp_rdata = io_sram_q. Writes: io_rsp_rdata = 0.
  - Latency is 2 cycles; throughput is 1 request per cycle.
  - There is no response backpressure; requesters must always accept.
- No grant in T: sram_cen = 0 in T+1; other io_sram_* hold their last values.
- Ordering:
  - Accesses reach the SRAM in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
  - wstrb is ignored on reads.
  - Unstrobed bytes keep their old value.
- Reset mid-operation: in-flight requests are dropped, so no rsp_valid follows. The block re-enters INIT, io_init_done drops, and rr_ptr returns to 0.
- Responses with rsp_valid = 0: io_rsp_rdata = 0.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined:
  - Adds outputs io_perf_p0_grants, io_perf_p1_grants and io_perf_conflicts, each 32 bits.
  - Grant counters count RUN grants per port. The conflict counter counts RUN cycles with both valid.
  - All three saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Release reset -> io_init_done rises 256 cycles later (CLEAR_ON_RESET = 1). A p0 read of adr 0xA7 then returns rdata 0x00000000.
- p0 write adr 0x10, d 0xDEADBEEF, wstrb 0xF; then p0 read 0x10 -> p0_rsp_valid 2 cycles after the read handshake, rdata 0xDEADBEEF.
- Write adr 0x20, 0x11223344, strb 0xF; then write 0xAABBCCDD, strb 0x5; then read 0x20 -> rdata 0x11BB33DD.
- Both ports hold valid reads continuously:
  - Grants alternate p0, p1, p0, ...; the first grant is p0.
  - Each rsp_valid appears only on the issuing port, with that port's address data.
- Assert reset one cycle after a read handshake -> no rsp_valid for that read, io_init_done = 0, and INIT restarts at adr 0.
- With SRAM_ARB_PERF_EN: 10 contested cycles -> conflicts = 10, p0_grants = 5, p1_grants = 5.
